// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - single-outstanding data-bus memory responder with fixed latency
//
// Ports:
//   clk, resetn          clock (posedge) and synchronous active-low reset
//   dreq_valid_i         request present; held with all fields until data_ok
//   dreq_addr_i  [31:0]  byte address; word index is addr[DEPTH_LOG2+1:2]
//   dreq_size_i  [2:0]   access size code (all codes behave as a 32-bit access)
//   dreq_strobe_i[3:0]   byte-lane write enables; zero means read
//   dreq_data_i  [31:0]  lane-replicated write data
//   dresp_addr_ok_o      request accepted this cycle (combinational from dreq_valid_i)
//   dresp_data_ok_o      one-cycle completion pulse, LATENCY cycles after acceptance
//   dresp_data_o [31:0]  read word while data_ok is high, otherwise zero
//   busy_o               high from the acceptance cycle through the data_ok cycle
module dbus_mem_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dreq_valid_i,
  input  logic [31:0] dreq_addr_i,
  input  logic [2:0]  dreq_size_i,
  input  logic [3:0]  dreq_strobe_i,
  input  logic [31:0] dreq_data_i,
  output logic        dresp_addr_ok_o,
  output logic        dresp_data_ok_o,
  output logic [31:0] dresp_data_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [3:0]              strobe_q, strobe_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             mem_q [0:(1<<DEPTH_LOG2)-1];

  // Size code, aliasing upper address bits and byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{dreq_size_i, dreq_addr_i[31:DEPTH_LOG2+2], dreq_addr_i[1:0]};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    strobe_d        = strobe_q;
    wdata_d         = wdata_q;
    dresp_addr_ok_o = 1'b0;
    dresp_data_ok_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dreq_valid_i) begin
          dresp_addr_ok_o = 1'b1;
          idx_d           = dreq_addr_i[DEPTH_LOG2+1:2];
          strobe_d        = dreq_strobe_i;
          wdata_d         = dreq_data_i;
          cnt_d           = 4'(LATENCY - 1);
          state_d         = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaching zero on this edge means the next cycle is the response.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        dresp_data_ok_o = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are silenced for the whole cycle while reset is asserted.
    if (!resetn) begin
      dresp_addr_ok_o = 1'b0;
      dresp_data_ok_o = 1'b0;
    end
  end

  assign busy_o       = resetn && ((state_q != S_IDLE) || dresp_addr_ok_o);
  assign dresp_data_o = (dresp_data_ok_o && (strobe_q == 4'd0)) ? mem_q[idx_q] : 32'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      strobe_q <= 4'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  // Write commits on the edge closing the response cycle; reset there drops it.
  always_ff @(posedge clk) begin
    if (resetn && (state_q == S_RESP)) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - scoreboard bench for dbus_mem_responder
module tb_dbus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        addr_ok, data_ok, busy;
  logic [31:0] rdata;

  dbus_mem_responder #(.LATENCY(2), .DEPTH_LOG2(12)) dut (
    .clk(clk), .resetn(resetn),
    .dreq_valid_i(dreq_valid), .dreq_addr_i(dreq_addr), .dreq_size_i(dreq_size),
    .dreq_strobe_i(dreq_strobe), .dreq_data_i(dreq_data),
    .dresp_addr_ok_o(addr_ok), .dresp_data_ok_o(data_ok),
    .dresp_data_o(rdata), .busy_o(busy)
  );

  // Extra instances for the latency extremes.
  logic [1:0]  xv;
  logic [31:0] x_addr, x_data;
  logic [3:0]  x_strobe;
  logic [1:0]  x_aok, x_dok, x_busy;
  logic [31:0] x_rd0, x_rd1;

  dbus_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) dut_l1 (
    .clk(clk), .resetn(resetn),
    .dreq_valid_i(xv[0]), .dreq_addr_i(x_addr), .dreq_size_i(3'd2),
    .dreq_strobe_i(x_strobe), .dreq_data_i(x_data),
    .dresp_addr_ok_o(x_aok[0]), .dresp_data_ok_o(x_dok[0]),
    .dresp_data_o(x_rd0), .busy_o(x_busy[0])
  );

  dbus_mem_responder #(.LATENCY(15), .DEPTH_LOG2(4)) dut_l15 (
    .clk(clk), .resetn(resetn),
    .dreq_valid_i(xv[1]), .dreq_addr_i(x_addr), .dreq_size_i(3'd2),
    .dreq_strobe_i(x_strobe), .dreq_data_i(x_data),
    .dresp_addr_ok_o(x_aok[1]), .dresp_data_ok_o(x_dok[1]),
    .dresp_data_o(x_rd1), .busy_o(x_busy[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference memory: word index -> contents.
  logic [31:0] model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_rw(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] e);
    int i;
    logic [31:0] w;
    i = int'(a[13:2]);
    w = model.exists(i) ? model[i] : 32'hxxxxxxxx;
    if (s == 4'd0) begin
      e = w;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[i] = w;
      e = 32'd0;
    end
  endtask

  // One request on the main DUT. Entered and left at posedge+1.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit keep_valid, output int acc);
    int n;
    logic [31:0] e;
    acc = -1;
    dreq_valid  = 1'b1;
    dreq_addr   = a;
    dreq_strobe = s;
    dreq_data   = d;
    dreq_size   = 3'($urandom_range(0, 7));
    n = 0;
    do begin @(negedge clk); n++; end while (!addr_ok && n < 50);
    if (!addr_ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      dreq_valid = 1'b0;
      return;
    end
    acc = cyc;
    model_rw(a, s, d, e);
    sb.push_back('{acc + 2, e});
    // Fields change after acceptance; the latched copy must be used.
    @(posedge clk); #1;
    dreq_addr   = $urandom;
    dreq_strobe = 4'($urandom);
    dreq_data   = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_ok && n < 50);
    if (!data_ok) check("data_ok_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep_valid) dreq_valid = 1'b0;
  endtask

  task automatic lat_run(input int w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int lat, output int bcnt,
                         output logic [31:0] rd);
    int  acc;
    int  n;
    bit  done;
    acc = -1; n = 0; done = 0;
    lat = -1; bcnt = 0; rd = 32'hxxxxxxxx;
    x_addr = a; x_strobe = s; x_data = d;
    xv[w] = 1'b1;
    while (!done && n < 60) begin
      @(negedge clk); n++;
      if (x_busy[w]) bcnt++;
      if (x_aok[w] && acc < 0) acc = cyc;
      if (x_dok[w]) begin
        lat  = cyc - acc;
        rd   = (w == 1) ? x_rd1 : x_rd0;
        done = 1;
      end
      if (acc >= 0 && xv[w]) begin
        @(posedge clk); #1;
        xv[w] = 1'b0;
      end
    end
    xv[w] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: checks every cycle of the main DUT against the scoreboard.
  bit in_flight = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      check("rst_addr_ok", addr_ok, 1'b0);
      check("rst_data_ok", data_ok, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data", rdata, 32'd0);
      in_flight = 0;
    end else begin
      check("addr_ok", addr_ok, dreq_valid && !in_flight);
      check("busy", busy, (dreq_valid && !in_flight) || in_flight);
      if (data_ok) begin
        if (sb.size() == 0) begin
          check("unexpected_data_ok", data_ok, 1'b0);
        end else begin
          e = sb.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_data", rdata, e.data);
        end
        in_flight = 0;
      end else begin
        check("idle_data_zero", rdata, 32'd0);
        if (sb.size() > 0 && cyc >= sb[0].cyc) begin
          e = sb.pop_front();
          check("resp_missing", cyc, e.cyc - 1);
        end
      end
      if (addr_ok) in_flight = 1;
    end
  end

  initial begin
    int a1, a2, lat, bc, n, idx_list[8];
    logic [31:0] rd, addr;
    logic [3:0]  s;
    bit          b2b;

    resetn = 1'b0;
    dreq_valid = 1'b1;
    dreq_addr = 32'h10; dreq_strobe = 4'hF; dreq_data = 32'h0; dreq_size = 3'd2;
    xv = 2'b00; x_addr = 32'd0; x_strobe = 4'd0; x_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    dreq_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Word write then read-back, byte-lane merge, back-to-back held valid.
    issue(32'h00000010, 4'hF, 32'h11223344, 0, a1);
    issue(32'h00000010, 4'h0, 32'h0, 0, a1);
    issue(32'h00000011, 4'b0010, 32'hABABABAB, 0, a1);
    issue(32'h00000010, 4'h0, 32'h0, 0, a1);
    issue(32'h00000010, 4'h0, 32'h0, 1, a1);
    issue(32'h00000012, 4'h0, 32'h0, 0, a2);
    check("b2b_accept_gap", a2 - a1, 3);

    // Address aliasing and read-after-write with no gap.
    issue(32'h00004000, 4'hF, 32'hDEADBEEF, 0, a1);
    issue(32'h00000000, 4'h0, 32'h0, 0, a1);
    issue(32'h00000020, 4'hF, 32'hCAFEF00D, 1, a1);
    issue(32'h00000020, 4'h0, 32'h0, 0, a1);

    // Reset while a write waits: request dropped, memory untouched.
    dreq_valid = 1'b1; dreq_addr = 32'h20; dreq_strobe = 4'hF; dreq_data = 32'h55AA55AA;
    n = 0;
    do begin @(negedge clk); n++; end while (!addr_ok && n < 20);
    check("abandon_accept", addr_ok, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dreq_valid = 1'b0;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h00000020, 4'h0, 32'h0, 0, a1);

    // Randomized traffic over a small set of words with random alias bits.
    for (int i = 0; i < 8; i++) begin
      idx_list[i] = $urandom_range(0, 4095);
      addr = ($urandom & 32'hFFFFC003) | (32'(idx_list[i]) << 2);
      issue(addr, 4'hF, $urandom, 0, a1);
    end
    for (int k = 0; k < 80; k++) begin
      addr = ($urandom & 32'hFFFFC003) | (32'(idx_list[$urandom_range(0, 7)]) << 2);
      s    = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
      b2b  = (k != 79) && ($urandom_range(0, 1) == 1);
      issue(addr, s, $urandom, b2b, a1);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    // Latency extremes.
    lat_run(0, 32'h8, 4'hF, 32'h01020304, lat, bc, rd);
    check("l1_latency", lat, 1);
    check("l1_busy_cycles", bc, 2);
    lat_run(0, 32'h8, 4'h0, 32'h0, lat, bc, rd);
    check("l1_read", rd, 32'h01020304);
    lat_run(1, 32'hC, 4'hF, 32'hA5A5F00F, lat, bc, rd);
    check("l15_latency", lat, 15);
    check("l15_busy_cycles", bc, 16);
    lat_run(1, 32'hC, 4'h0, 32'h0, lat, bc, rd);
    check("l15_read", rd, 32'hA5A5F00F);

    n = 0;
    while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
DBUS_MEM_RESPONDER -- requirements
Module: dbus_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from request acceptance to data_ok; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12: log2 of memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-004 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port dreq.valid, input, 1: request present; the initiator holds it and all request fields stable until data_ok.
REQ-006 SHALL have port dreq.addr, input, 32: physical byte address.
REQ-007 SHALL have port dreq.size, input, 3: access size code; MSIZE4 only is honoured, other codes treated identically.
REQ-008 SHALL have port dreq.strobe, input, 4: byte-lane write enables; 4'b0000 = read.
REQ-009 SHALL have port dreq.data, input, 32: write data, already lane-replicated by the initiator.
REQ-010 SHALL have port dresp.addr_ok, output, 1: request accepted this cycle.
REQ-011 SHALL have port dresp.data_ok, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port dresp.data, output, 32: full aligned read word, valid only while data_ok=1.
REQ-013 SHALL have port busy, output, 1: high from acceptance through the data_ok cycle.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE: addr_ok = dreq.valid, combinationally in the same cycle; on valid, SHALL latch addr, strobe and data, load the counter with LATENCY-1, and go to WAIT, or directly to RESP when LATENCY=1.
REQ-016 WAIT: SHALL decrement the counter each cycle and go to RESP when it reaches 0; addr_ok=0.
REQ-017 RESP: data_ok=1 for exactly one cycle, addr_ok=0, then SHALL return to IDLE unconditionally.
REQ-018 Acceptance at cycle T SHALL produce data_ok at cycle T+LATENCY exactly.
REQ-019 A held dreq.valid in the cycle after data_ok SHALL be treated as a new request, accepted because the FSM is in IDLE.
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses alias with wrap-around; addr[1:0] is ignored.
REQ-021 Write (strobe≠0): SHALL update only the lanes whose strobe bit is set, at the posedge ending the RESP cycle; dresp.data = 32'd0 in that cycle.
REQ-022 Read (strobe=0): dresp.data SHALL equal the stored word at the index as of the RESP cycle; memory is unchanged.
REQ-023 A read accepted immediately after a write's data_ok, to the same index, SHALL return the updated word with no bypass hazard.
REQ-024 dresp.data SHALL be 32'd0 whenever data_ok=0.
REQ-025 Changes to dreq fields after acceptance SHALL be ignored; the latched copies are used.

Reset
REQ-026 While resetn=0 at a posedge: state SHALL become IDLE, counter 0, latched request cleared, addr_ok=0, data_ok=0, dresp.data=0, busy=0.
REQ-027 addr_ok SHALL be 0 throughout any cycle in which resetn=0, regardless of dreq.valid.
REQ-028 Reset during WAIT or RESP SHALL abandon the request; a pending write SHALL NOT modify memory.
REQ-029 Memory array contents SHALL NOT be reset.

Verification
REQ-030 LATENCY=2: write addr 0x00000010, strobe 4'b1111, data 0x11223344 -> addr_ok at T, data_ok at T+2 only; then read 0x10 -> data 0x11223344.
REQ-031 Byte write to 0x00000011, strobe 4'b0010, data 0xABABABAB over 0x11223344 -> read of 0x10 returns 0x1122AB44.
REQ-032 Valid held continuously across two back-to-back reads -> two data_ok pulses 3 cycles apart (LATENCY=2), each preceded by addr_ok.
REQ-033 LATENCY=1 -> data_ok in cycle T+1; LATENCY=15 -> data_ok at T+15 and busy high for 16 cycles.
REQ-034 Write accepted, then resetn=0 asserted in WAIT -> no data_ok; after reset, a read of the same address returns the prior contents.
REQ-035 DEPTH_LOG2=12: write 0xDEADBEEF to 0x00004000 -> read of 0x00000000 returns 0xDEADBEEF (alias).
